// File: rtl/step_pulse_gen_if.sv
// Step/direction generator bus: move requests and rate clock in, driver pins and status out.
interface step_pulse_gen_if #(
  parameter int COUNT_BITS = 32
);
  logic                  rate_clk;
  logic                  start;
  logic                  dir_in;
  logic [COUNT_BITS-1:0] steps;
  logic                  abort;
  logic                  step;
  logic                  dir;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  logic [COUNT_BITS-1:0] position;
  logic [COUNT_BITS-1:0] remaining;

  modport master (
    output rate_clk, start, dir_in, steps, abort,
    input  step, dir, busy, done, overrun, position, remaining
  );

  modport slave (
    input  rate_clk, start, dir_in, steps, abort,
    output step, dir, busy, done, overrun, position, remaining
  );
endinterface

// File: rtl/step_pulse_gen.sv
// Turns rate-clock rising edges into width-guaranteed step pulses with direction setup,
// one relative move per start, and a wrapping signed position counter.
module step_pulse_gen #(
  parameter int COUNT_BITS  = 32,
  parameter int PULSE_WIDTH = 16,
  parameter int DIR_SETUP   = 8
) (
  input logic             clk,
  input logic             rst,
  step_pulse_gen_if.slave sp
);
  localparam int MAX_CNT = (PULSE_WIDTH > DIR_SETUP) ? PULSE_WIDTH : DIR_SETUP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_HIGH,
    ST_LOW,
    ST_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rateQ;
  logic                  r_pending;
  logic                  r_step;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overrun;
  logic [COUNT_BITS-1:0] r_position;
  logic [COUNT_BITS-1:0] r_remaining;
  logic                  w_tick;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_inPulse;

  assign w_tick    = sp.rate_clk & ~r_rateQ;
  assign w_accept  = (r_state == ST_IDLE) & sp.start;
  assign w_fire    = (r_state == ST_WAIT) & (w_nextState == ST_HIGH);
  assign w_inPulse = (r_state == ST_HIGH) | (r_state == ST_LOW);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (sp.start) begin
          w_nextState = (sp.steps == '0) ? ST_FINISH : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == CNT_W'(DIR_SETUP - 1)) begin
          w_nextState = ST_WAIT;
        end
      end
      // A buffered or fresh tick outranks abort, so the last requested pulse still goes out.
      ST_WAIT: begin
        if (w_tick || r_pending) begin
          w_nextState = ST_HIGH;
        end else if (sp.abort) begin
          w_nextState = ST_FINISH;
        end
      end
      ST_HIGH: begin
        if (r_cnt == CNT_W'(PULSE_WIDTH - 1)) begin
          w_nextState = ST_LOW;
        end
      end
      ST_LOW: begin
        if (r_cnt == CNT_W'(PULSE_WIDTH - 1)) begin
          w_nextState = ((r_remaining == '0) || sp.abort) ? ST_FINISH : ST_WAIT;
        end
      end
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rateQ <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_rateQ <= sp.rate_clk;
      if (w_nextState != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_SETUP) || w_inPulse) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pending   <= 1'b0;
      r_position  <= '0;
      r_remaining <= '0;
    end else begin
      r_step <= (w_nextState == ST_HIGH);
      r_done <= (r_state == ST_FINISH);
      if (r_state == ST_FINISH) begin
        r_busy <= 1'b0;
      end
      if (w_accept) begin
        r_dir       <= sp.dir_in;
        r_remaining <= sp.steps;
        r_overrun   <= 1'b0;
        r_pending   <= 1'b0;
        r_busy      <= 1'b1;
      end
      if (w_fire) begin
        r_pending  <= 1'b0;
        r_position <= r_dir ? (r_position + COUNT_BITS'(1)) : (r_position - COUNT_BITS'(1));
        if (r_remaining != '0) begin
          r_remaining <= r_remaining - COUNT_BITS'(1);
        end
      end
      // Only one tick can be buffered while a pulse and its low time are in progress.
      if (w_inPulse && w_tick) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign sp.step      = r_step;
  assign sp.dir       = r_dir;
  assign sp.busy      = r_busy;
  assign sp.done      = r_done;
  assign sp.overrun   = r_overrun;
  assign sp.position  = r_position;
  assign sp.remaining = r_remaining;
endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed and randomized moves checked against an edge-timeline model of pulses,
// buffered ticks, overrun, position and completion timing.
module tb_step_pulse_gen;
  localparam int CB = 32;
  localparam int PW = 16;
  localparam int DS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned ratePeriod = 0;
  int unsigned ratePhase = 0;
  logic [CB-1:0] modelPos = '0;

  int unsigned riseQ[$];
  int unsigned highQ[$];
  int unsigned doneQ[$];
  int unsigned highCnt = 0;
  logic        prevStep = 1'b0;

  step_pulse_gen_if #(.COUNT_BITS(CB)) sp ();

  step_pulse_gen #(
    .COUNT_BITS (CB),
    .PULSE_WIDTH(PW),
    .DIR_SETUP  (DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sp (sp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Rate clock rises just after edge k when (k - phase) is a multiple of the period,
  // so the DUT sees that tick at edge k+1.
  always @(posedge clk) begin
    #1;
    if (ratePeriod >= 2 && cyc >= ratePhase)
      sp.rate_clk = ((cyc - ratePhase) % ratePeriod) < (ratePeriod / 2);
    else
      sp.rate_clk = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (sp.step && !prevStep) riseQ.push_back(cyc);
    if (sp.step) highCnt++;
    if (!sp.step && prevStep) highQ.push_back(highCnt);
    if (!sp.step) highCnt = 0;
    if (sp.done) doneQ.push_back(cyc);
    prevStep = sp.step;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clearMonitors();
    riseQ.delete();
    highQ.delete();
    doneQ.delete();
  endtask

  // Presents a one-cycle start; returns the edge at which it is sampled and the rate phase.
  task automatic startMove(input int unsigned nSteps, input bit d, input int unsigned period,
                           output int unsigned n, output int unsigned ph);
    ph = cyc + 3 + $urandom_range(0, period - 1);
    ratePeriod = period;
    ratePhase  = ph;
    n = cyc + 1;
    sp.start  = 1'b1;
    sp.steps  = nSteps;
    sp.dir_in = d;
    nextCycle();
    sp.start  = 1'b0;
    sp.steps  = $urandom;
    sp.dir_in = $urandom_range(0, 1);
  endtask

  task automatic applyStimulus(input int unsigned nSteps, input bit d, input int unsigned period,
                               input bit injectStart, input string tag);
    int unsigned n, ph, t, p, c, horizon, doneEdge;
    int unsigned ticks[$];
    int unsigned expRise[$];
    bit pend, ovr;
    clearMonitors();
    startMove(nSteps, d, period, n, ph);
    checkOutput({tag, ".busy"}, sp.busy, 1);
    checkOutput({tag, ".dir"}, sp.dir, d);

    horizon = n + DS + (nSteps + 2) * (2 * PW + period + 2) + 20;
    for (int unsigned k = ph + 1; k <= horizon; k += period) ticks.push_back(k);
    t = n + DS + 1;
    p = 0;
    pend = 0;
    ovr = 0;
    for (int i = 0; i < int'(nSteps); i++) begin
      if (pend) begin
        p = t;
        pend = 0;
      end else begin
        while (ticks.size() > 0 && ticks[0] < t) void'(ticks.pop_front());
        p = ticks[0];
      end
      while (ticks.size() > 0 && ticks[0] <= p) void'(ticks.pop_front());
      c = 0;
      while (ticks.size() > 0 && ticks[0] <= p + 2 * PW) begin
        c++;
        void'(ticks.pop_front());
      end
      if (c >= 1) pend = 1;
      if (c >= 2) ovr = 1;
      expRise.push_back(p);
      t = p + 2 * PW + 1;
    end
    doneEdge = (nSteps == 0) ? n + 1 : p + 2 * PW + 1;
    modelPos = d ? modelPos + CB'(nSteps) : modelPos - CB'(nSteps);

    if (injectStart) begin
      nextCycle();
      nextCycle();
      sp.start  = 1'b1;
      sp.steps  = 1234;
      sp.dir_in = ~d;
      nextCycle();
      sp.start  = 1'b0;
    end
    while (cyc < doneEdge + 2) nextCycle();

    checkOutput({tag, ".pulses"}, riseQ.size(), nSteps);
    for (int i = 0; i < expRise.size() && i < riseQ.size(); i++)
      checkOutput($sformatf("%s.rise%0d", tag, i), riseQ[i], expRise[i]);
    for (int i = 0; i < highQ.size(); i++)
      checkOutput($sformatf("%s.high%0d", tag, i), highQ[i], PW);
    checkOutput({tag, ".doneCount"}, doneQ.size(), 1);
    if (doneQ.size() > 0) checkOutput({tag, ".doneEdge"}, doneQ[0], doneEdge);
    checkOutput({tag, ".position"}, sp.position, modelPos);
    checkOutput({tag, ".remaining"}, sp.remaining, 0);
    checkOutput({tag, ".overrun"}, sp.overrun, ovr);
    checkOutput({tag, ".busyEnd"}, sp.busy, 0);
    checkOutput({tag, ".dirHeld"}, sp.dir, d);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".step"}, sp.step, 0);
    checkOutput({tag, ".dir"}, sp.dir, 0);
    checkOutput({tag, ".busy"}, sp.busy, 0);
    checkOutput({tag, ".done"}, sp.done, 0);
    checkOutput({tag, ".overrun"}, sp.overrun, 0);
    checkOutput({tag, ".position"}, sp.position, 0);
    checkOutput({tag, ".remaining"}, sp.remaining, 0);
  endtask

  initial begin
    int unsigned n, ph, budget;
    sp.rate_clk = 1'b0;
    sp.start    = 1'b0;
    sp.dir_in   = 1'b0;
    sp.steps    = '0;
    sp.abort    = 1'b0;

    nextCycle();
    nextCycle();
    checkResetValues("reset");
    rst = 1'b0;
    nextCycle();

    applyStimulus(5, 1'b1, 100, 1'b0, "basic");
    applyStimulus(0, 1'b1, 30, 1'b0, "zeroSteps");
    applyStimulus(8, 1'b0, 60, 1'b1, "startWhileBusy");
    applyStimulus(4, 1'b1, 10, 1'b0, "overrun");
    checkOutput("overrun.sticky", sp.overrun, 1);

    // Abort held from inside the third pulse until completion.
    clearMonitors();
    startMove(100, 1'b1, 40, n, ph);
    budget = 0;
    while (riseQ.size() < 3 && budget < 3000) begin
      nextCycle();
      budget++;
    end
    checkOutput("abort.reachThird", riseQ.size(), 3);
    sp.abort = 1'b1;
    budget = 0;
    while (doneQ.size() == 0 && budget < 2000) begin
      nextCycle();
      budget++;
    end
    sp.abort = 1'b0;
    nextCycle();
    modelPos = modelPos + CB'(3);
    checkOutput("abort.doneCount", doneQ.size(), 1);
    checkOutput("abort.pulses", riseQ.size(), 3);
    for (int i = 0; i < highQ.size(); i++)
      checkOutput($sformatf("abort.high%0d", i), highQ[i], PW);
    checkOutput("abort.position", sp.position, modelPos);
    checkOutput("abort.remaining", sp.remaining, 97);
    checkOutput("abort.busy", sp.busy, 0);

    // Asynchronous reset landing in the middle of a high phase.
    clearMonitors();
    startMove(6, 1'b1, 40, n, ph);
    budget = 0;
    while (!sp.step && budget < 2000) begin
      nextCycle();
      budget++;
    end
    checkOutput("rstMid.stepSeen", sp.step, 1);
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMid.step", sp.step, 0);
    checkOutput("rstMid.busy", sp.busy, 0);
    checkOutput("rstMid.position", sp.position, 0);
    checkOutput("rstMid.remaining", sp.remaining, 0);
    #1;
    rst = 1'b0;
    modelPos = '0;
    nextCycle();
    applyStimulus(2, 1'b1, 50, 1'b0, "afterReset");

    rst = 1'b1;
    #2;
    rst = 1'b0;
    modelPos = '0;
    nextCycle();
    applyStimulus(3, 1'b0, 70, 1'b0, "reverseWrap");
    checkOutput("reverseWrap.value", sp.position, 32'hFFFF_FFFD);

    for (int r = 0; r < 8; r++) begin
      applyStimulus($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(3, 80),
                    1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
